// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-2 Booth multiplier control path.
// Holds the state encoding, the default widths and the Booth operation decode.
package booth_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = $clog2(WIDTH_DEF) + 1;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t LOAD  = 3'd1;
    localparam state_t EVAL  = 3'd2;
    localparam state_t SHIFT = 3'd3;
    localparam state_t DONE  = 3'd4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic ld_a;
        logic oper;
    } booth_op_t;

    // {q0,qm1}: 01 -> A+M, 10 -> A-M, 00/11 -> no accumulate (oper held at add)
    function automatic booth_op_t booth_decode(input logic q0, input logic qm1);
        booth_op_t op;
        op.ld_a = q0 ^ qm1;
        op.oper = OP_ADD;
        if (q0 && !qm1) begin
            op.oper = OP_SUB;
        end
        return op;
    endfunction

endpackage

// File: rtl/booth_iter_counter.sv
// Iteration down-counter for the Booth sequencer: loads WIDTH, decrements
// once per shift, and flags the final iteration with a terminal-count compare.
module booth_iter_counter
    import booth_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    // clr (abort) outranks load, load outranks dec; zero is a hard floor
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - ONE;
        end
    end

    assign last = (cnt == ONE);

endmodule

// File: rtl/booth_seq_ctrl.sv
// Control-path sequencer for a radix-2 Booth multiplier datapath: loads the
// operands, runs WIDTH evaluate/shift iterations and pulses done on completion.
//
// state | meaning
// IDLE  | waiting for start; all controls low
// LOAD  | load M and Q, clear A and Q-1, preset the iteration counter
// EVAL  | decode {q0,qm1}: add, subtract or hold A
// SHIFT | arithmetic right shift of {A,Q,Q-1}; count one iteration
// DONE  | one-cycle done pulse, product valid in {A,Q}
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             q0,
    input  logic             qm1,
    output logic             ldM,
    output logic             ldQ,
    output logic             clrA,
    output logic             clrFF,
    output logic             ldA,
    output logic             oper,
    output logic             sft,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cnt
);

    state_t    state;
    state_t    state_nx;
    logic      cnt_load;
    logic      cnt_dec;
    logic      cnt_clr;
    logic      cnt_last;
    booth_op_t eval_op;

    booth_iter_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .load  (cnt_load),
        .dec   (cnt_dec),
        .cnt   (cnt),
        .last  (cnt_last)
    );

    always_comb begin
        state_nx = state;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                cnt_load = 1'b1;
                state_nx = EVAL;
            end
            EVAL: begin
                state_nx = SHIFT;
            end
            SHIFT: begin
                cnt_dec  = 1'b1;
                state_nx = cnt_last ? DONE : EVAL;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        // abort overrides every transition but leaves this cycle's outputs alone
        if (abort && (state != IDLE)) begin
            state_nx = IDLE;
            cnt_load = 1'b0;
            cnt_dec  = 1'b0;
            cnt_clr  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    assign eval_op = booth_decode(q0, qm1);

    always_comb begin
        ldM   = 1'b0;
        ldQ   = 1'b0;
        clrA  = 1'b0;
        clrFF = 1'b0;
        ldA   = 1'b0;
        oper  = OP_ADD;
        sft   = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            LOAD: begin
                ldM   = 1'b1;
                ldQ   = 1'b1;
                clrA  = 1'b1;
                clrFF = 1'b1;
                busy  = 1'b1;
            end
            EVAL: begin
                ldA  = eval_op.ld_a;
                oper = eval_op.oper;
                busy = 1'b1;
            end
            SHIFT: begin
                sft  = 1'b1;
                busy = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    a_cnt_no_underflow: assert property (
        @(posedge clk) disable iff (!rst_n) (state == SHIFT) |-> (cnt != '0)
    );

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Bench for booth_seq_ctrl: a reference Booth datapath driven by the DUT
// controls, a product scoreboard checked on done, and a per-cycle output model.
module tb_booth_seq_ctrl;

    localparam int W  = 16;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          q0_w;
    logic          qm1_w;
    logic          ldM, ldQ, clrA, clrFF, ldA, oper, sft, busy, done;
    logic [CW-1:0] cnt;

    logic          force_en = 1'b0;
    logic          f_q0 = 1'b0;
    logic          f_qm1 = 1'b0;
    logic [15:0]   mc_in = '0;
    logic [15:0]   mp_in = '0;

    // reference datapath; A carries a guard bit so a -32768 multiplicand is exact
    logic [16:0]   a_r = '0;
    logic [15:0]   q_r = '0;
    logic [15:0]   m_r = '0;
    logic          qm1_r = 1'b0;

    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int            start_cyc = 0;
    bit            run_valid = 1'b0;

    typedef struct {
        logic [31:0] prod;
        int          scyc;
        bit          chk_prod;
    } sb_t;
    sb_t sb[$];

    booth_seq_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .q0    (q0_w),
        .qm1   (qm1_w),
        .ldM   (ldM),
        .ldQ   (ldQ),
        .clrA  (clrA),
        .clrFF (clrFF),
        .ldA   (ldA),
        .oper  (oper),
        .sft   (sft),
        .busy  (busy),
        .done  (done),
        .cnt   (cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign q0_w  = force_en ? f_q0  : q_r[0];
    assign qm1_w = force_en ? f_qm1 : qm1_r;

    always @(posedge clk) begin
        if (ldM)   m_r   <= mc_in;
        if (ldQ)   q_r   <= mp_in;
        if (clrA)  a_r   <= '0;
        if (clrFF) qm1_r <= 1'b0;
        if (ldA)   a_r   <= oper ? (a_r - {m_r[15], m_r}) : (a_r + {m_r[15], m_r});
        if (sft)   {a_r, q_r, qm1_r} <= {a_r[16], a_r, q_r};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [13:0] outs_vec();
        return {ldM, ldQ, clrA, clrFF, ldA, oper, sft, busy, done, cnt};
    endfunction

    // expected outputs derived from the cycle offset since the accepted start
    function automatic logic [13:0] model_vec();
        logic          e_ld, e_ldA, e_oper, e_sft, e_busy, e_done;
        logic [CW-1:0] e_cnt;
        int            off;
        e_ld = 0; e_ldA = 0; e_oper = 0; e_sft = 0; e_busy = 0; e_done = 0; e_cnt = '0;
        off = cyc - start_cyc;
        if (run_valid && off >= 1 && off <= 34) begin
            if (off == 1) begin
                e_ld = 1; e_busy = 1;
            end else if (off <= 33) begin
                e_busy = 1;
                e_cnt  = CW'(16 - (off - 2) / 2);
                if (off % 2 == 1) begin
                    e_sft = 1;
                end else begin
                    if ({q0_w, qm1_w} == 2'b01) e_ldA = 1;
                    if ({q0_w, qm1_w} == 2'b10) begin e_ldA = 1; e_oper = 1; end
                end
            end else begin
                e_done = 1;
            end
        end
        return {e_ld, e_ld, e_ld, e_ld, e_ldA, e_oper, e_sft, e_busy, e_done, e_cnt};
    endfunction

    initial begin : monitor
        sb_t e;
        forever begin
            @(negedge clk);
            check("outs", {18'd0, outs_vec()}, {18'd0, model_vec()});
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_latency", 32'(cyc - e.scyc), 32'd34);
                    if (e.chk_prod) check("product", {a_r[15:0], q_r}, e.prod);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] mc, input logic [15:0] mp,
                            input logic [31:0] prod, input bit push, input bit chk);
        sb_t e;
        mc_in = mc;
        mp_in = mp;
        start = 1'b1;
        start_cyc = cyc;
        run_valid = 1'b1;
        if (push) begin
            e.prod = prod; e.scyc = cyc; e.chk_prod = chk;
            sb.push_back(e);
        end
        tick(1);
        start = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    logic [1:0] pat [4] = '{2'b10, 2'b01, 2'b00, 2'b11};

    initial begin : stim
        #1;
        tick(3);
        check("reset_outs", {18'd0, outs_vec()}, 32'd0);
        rst_n = 1'b1;
        tick(10);

        do_start(16'd3, 16'hFFFB, 32'hFFFF_FFF1, 1, 1);
        tick(40);
        do_start(16'h8000, 16'h8000, 32'h4000_0000, 1, 1);
        tick(40);
        do_start(16'h0000, 16'h7FFF, 32'h0000_0000, 1, 1);
        tick(40);

        // ignored starts at offsets 5 and 20, then a back-to-back start at 35
        do_start(16'd7, 16'd6, 32'd42, 1, 1);
        tick(4);
        pulse_start();
        tick(14);
        pulse_start();
        tick(14);
        do_start(16'hFFFE, 16'd5, 32'hFFFF_FFF6, 1, 1);
        tick(40);

        start = 1'b1;
        abort = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        tick(3);

        force_en = 1'b1;
        do_start(16'd1, 16'd1, 32'd0, 1, 0);
        for (int i = 0; i < 16; i++) begin
            {f_q0, f_qm1} = pat[i % 4];
            tick(2);
        end
        tick(3);
        force_en = 1'b0;
        tick(2);

        // abort during the 7th SHIFT (offset 15)
        do_start(16'd5, 16'd5, 32'd25, 0, 0);
        tick(14);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        run_valid = 1'b0;
        tick(3);
        do_start(16'd5, 16'd5, 32'd25, 1, 1);
        tick(40);

        // reset during EVAL of the 10th iteration (offset 20)
        do_start(16'd9, 16'd9, 32'd81, 0, 0);
        tick(19);
        #2;
        rst_n = 1'b0;
        run_valid = 1'b0;
        #1;
        check("async_reset_outs", {18'd0, outs_vec()}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(5);
        do_start(16'hFFFF, 16'hFFFF, 32'd1, 1, 1);
        tick(40);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
